// File: rtl/gray_pkg.sv
// Shared types and default sizing for the Gray-code decoder slice.
package gray_pkg;

  localparam int GRAY_WIDTH_DEF = 3;
  localparam int CNT_W_DEF      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at and above its position.
module gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_decoder.sv
// Decodes a Gray-coded count, checks that consecutive samples follow a legal
// counter sequence, and reports wraps and sequence errors with saturating tallies.
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] binary_o,
  output logic             out_valid_o,
  output logic             wrap_o,
  output logic             error_o,
  output logic             locked_o,
  output logic [CNT_W-1:0] wrap_count_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam logic [WIDTH-1:0] CODE_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] binary_q;
  logic             out_valid_q;
  logic             wrap_q;
  logic             error_q;
  logic [CNT_W-1:0] wrap_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic [WIDTH-1:0] decode;
  logic [WIDTH-1:0] prev_inc;
  logic             step_hold;
  logic             step_inc;
  logic             step_wrap;
  logic [CNT_W-1:0] wrap_cnt_d;
  logic [CNT_W-1:0] err_cnt_d;

  gray2bin #(
    .WIDTH(WIDTH)
  ) u_gray2bin (
    .gray_i(gray_i),
    .bin_o (decode)
  );

  assign prev_inc = prev_q + WIDTH'(1);

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    step_hold  = 1'b0;
    step_inc   = 1'b0;
    step_wrap  = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    err_cnt_d  = err_cnt_q;

    if (decode == prev_q) begin
      step_hold = 1'b1;
    end else if (decode == prev_inc) begin
      step_inc  = 1'b1;
      step_wrap = (prev_q == CODE_MAX);
    end

    if (wrap_cnt_q != CNT_MAX) begin
      wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
    end
    if (err_cnt_q != CNT_MAX) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      binary_q    <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      error_q     <= 1'b0;
      wrap_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= in_valid_i;
      wrap_q      <= 1'b0;
      error_q     <= 1'b0;

      if (in_valid_i) begin
        binary_q <= decode;
        prev_q   <= decode;

        case (state_q)
          // Without a trusted reference, the first sample simply relocks.
          IDLE, FAULT: begin
            state_q <= TRACK;
          end
          TRACK: begin
            if (step_hold || step_inc) begin
              if (step_wrap) begin
                wrap_q     <= 1'b1;
                wrap_cnt_q <= wrap_cnt_d;
              end
            end else begin
              error_q   <= 1'b1;
              err_cnt_q <= err_cnt_d;
              state_q   <= FAULT;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign binary_o     = binary_q;
  assign out_valid_o  = out_valid_q;
  assign wrap_o       = wrap_q;
  assign error_o      = error_q;
  assign locked_o     = (state_q == TRACK);
  assign wrap_count_o = wrap_cnt_q;
  assign err_count_o  = err_cnt_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Bench for gray_decoder: directed scenarios with literal expectations plus a
// randomized run scored every cycle against a sequence-level reference model.
module tb_gray_decoder;

  localparam int W    = 3;
  localparam int N    = 1 << W;
  localparam int MAX8 = 255;
  localparam int MAX2 = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] gray;

  logic [W-1:0] bin8,  bin2;
  logic         ov8,   ov2;
  logic         wrap8, wrap2;
  logic         err8,  err2;
  logic         lock8, lock2;
  logic [7:0]   wcnt8, ecnt8;
  logic [1:0]   wcnt2, ecnt2;

  int n_checks = 0;
  int n_fail   = 0;

  gray_decoder #(.WIDTH(W), .CNT_W(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .gray_i      (gray),
    .binary_o    (bin8),
    .out_valid_o (ov8),
    .wrap_o      (wrap8),
    .error_o     (err8),
    .locked_o    (lock8),
    .wrap_count_o(wcnt8),
    .err_count_o (ecnt8)
  );

  gray_decoder #(.WIDTH(W), .CNT_W(2)) dut_c2 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .gray_i      (gray),
    .binary_o    (bin2),
    .out_valid_o (ov2),
    .wrap_o      (wrap2),
    .error_o     (err2),
    .locked_o    (lock2),
    .wrap_count_o(wcnt2),
    .err_count_o (ecnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decode by inverting the binary->Gray encoding table.
  int g2b_tbl [N];
  initial for (int b = 0; b < N; b++) g2b_tbl[b ^ (b >> 1)] = b;

  function automatic logic [W-1:0] b2g(input int b);
    return W'(b ^ (b >> 1));
  endfunction

  bit m_locked;
  int m_prev, m_bin, m_wraps, m_errs;
  bit m_ov, m_wrap, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked = 0; m_prev = 0; m_bin = 0; m_wraps = 0; m_errs = 0;
      m_ov = 0; m_wrap = 0; m_err = 0;
    end else begin
      int d;
      m_ov = in_valid; m_wrap = 0; m_err = 0;
      if (in_valid) begin
        d = g2b_tbl[gray];
        m_bin = d;
        if (!m_locked) begin
          m_locked = 1;
        end else if (d == m_prev) begin
          // upstream counter paused
        end else if (d == (m_prev + 1) % N) begin
          if (m_prev == N - 1) begin
            m_wrap = 1;
            m_wraps++;
          end
        end else begin
          m_err = 1;
          m_errs++;
          m_locked = 0;
        end
        m_prev = d;
      end
    end
  end

  always @(negedge clk) begin
    check("binary",       32'(bin8),  32'(m_bin));
    check("out_valid",    32'(ov8),   32'(m_ov));
    check("wrap",         32'(wrap8), 32'(m_wrap));
    check("error",        32'(err8),  32'(m_err));
    check("locked",       32'(lock8), 32'(m_locked));
    check("wrap_count",   32'(wcnt8), 32'(m_wraps > MAX8 ? MAX8 : m_wraps));
    check("err_count",    32'(ecnt8), 32'(m_errs > MAX8 ? MAX8 : m_errs));
    check("wrap_and_err", 32'(wrap8 & err8), 32'd0);
    check("c2_binary",    32'(bin2),  32'(m_bin));
    check("c2_flags",     {29'd0, ov2, wrap2, err2}, {29'd0, m_ov, m_wrap, m_err});
    check("c2_wrap_count",32'(wcnt2), 32'(m_wraps > MAX2 ? MAX2 : m_wraps));
    check("c2_err_count", 32'(ecnt2), 32'(m_errs > MAX2 ? MAX2 : m_errs));
  end

  task automatic cyc(input logic v, input logic [W-1:0] g);
    in_valid = v;
    gray     = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_binary"}, 32'(bin8), 32'd0);
    check({tag, "_flags"},  {28'd0, ov8, wrap8, err8, lock8}, 32'd0);
    check({tag, "_counts"}, {16'd0, wcnt8, ecnt8}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] seq33 [9];
    int wraps_seen;
    int cur;

    seq33 = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    rst_n = 1'b0; in_valid = 1'b0; gray = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Full count 0..7 and back to 0: exactly one wrap, no errors.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, seq33[i]);
      check("seq_binary", 32'(bin8), 32'(i % 8));
      check("seq_wrap",   32'(wrap8), (i == 8) ? 32'd1 : 32'd0);
      check("seq_error",  32'(err8), 32'd0);
    end
    check("seq_wrap_count", 32'(wcnt8), 32'd1);

    // Paused counter: repeated 011 holds Binary at 2.
    do_reset();
    cyc(1'b1, 3'b000); cyc(1'b1, 3'b001); cyc(1'b1, 3'b011);
    check("hold_locked", 32'(lock8), 32'd1);
    repeat (3) begin
      cyc(1'b1, 3'b011);
      check("hold_binary", 32'(bin8), 32'd2);
      check("hold_flags",  {29'd0, ov8, wrap8, err8}, 32'b100);
    end

    // Illegal jump 2 -> 5, then relock on 6.
    cyc(1'b1, 3'b111);
    check("jump_binary", 32'(bin8), 32'd5);
    check("jump_error",  32'(err8), 32'd1);
    check("jump_ecnt",   32'(ecnt8), 32'd1);
    check("jump_locked", 32'(lock8), 32'd0);
    cyc(1'b1, 3'b101);
    check("relock_binary", 32'(bin8), 32'd6);
    check("relock_error",  32'(err8), 32'd0);
    check("relock_locked", 32'(lock8), 32'd1);

    // Mid-cycle reset at Binary 4 clears outputs without a clock edge.
    do_reset();
    cyc(1'b1, 3'b000); cyc(1'b1, 3'b001); cyc(1'b1, 3'b011);
    cyc(1'b1, 3'b010); cyc(1'b1, 3'b110);
    check("pre_rst_binary", 32'(bin8), 32'd4);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 3'b110);
    check("post_rst_binary", 32'(bin8), 32'd4);
    check("post_rst_flags",  {29'd0, ov8, wrap8, err8}, 32'b100);

    // Five wraps: the 2-bit counter saturates at 3.
    do_reset();
    wraps_seen = 0;
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < N; b++) begin
        cyc(1'b1, b2g(b));
        wraps_seen += int'(wrap2);
      end
    end
    cyc(1'b1, 3'b000);
    wraps_seen += int'(wrap2);
    check("sat_wrap_pulses", 32'(wraps_seen), 32'd5);
    check("sat_c2_count",    32'(wcnt2), 32'd3);
    check("sat_c8_count",    32'(wcnt8), 32'd5);

    // Gaps in In_valid: ignored samples and no errors.
    do_reset();
    cyc(1'b1, 3'b000); check("gap_ov1", 32'(ov8), 32'd1);
    cyc(1'b0, 3'b111); check("gap_ov0", 32'(ov8), 32'd0);
    check("gap_hold", 32'(bin8), 32'd0);
    cyc(1'b1, 3'b001); check("gap_bin1", 32'(bin8), 32'd1);
    check("gap_err1", 32'(err8), 32'd0);
    cyc(1'b0, 3'b101); check("gap_ov0b", 32'(ov8), 32'd0);
    cyc(1'b1, 3'b011); check("gap_bin2", 32'(bin8), 32'd2);
    check("gap_err2", 32'(err8), 32'd0);

    // Randomized traffic, scored by the per-cycle compare process.
    do_reset();
    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset();
      end else if (r < 30) begin
        cyc(1'b0, W'($urandom));
      end else begin
        int sel;
        sel = int'($urandom_range(0, 99));
        if (sel < 65)      cur = (cur + 1) % N;
        else if (sel < 80) cur = cur;
        else               cur = int'($urandom_range(0, N - 1));
        cyc(1'b1, b2g(cur));
      end
    end
    cyc(1'b0, '0);
    cyc(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
